// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: decodes hsync/vsync/pixel into visible coordinates and tracks timing lock.
// Build option: define VGA_RX_CRC_EN to add a per-frame CRC-16-CCITT of the visible pixels.
module vga_rx_monitor #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter logic        SYNC_POL    = 1'b0,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  pixel,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic [3:0]  px_data,
    output logic        px_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic [15:0] frame_crc,
    output logic        crc_valid
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned CNT_W   = 10;
    localparam int unsigned GOOD_W  = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_TRACK  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    logic              hs1_q, hs1_d, hs2_q, hs2_d, vs1_q, vs1_d, vs2_q, vs2_d;
    logic [3:0]        pix1_q, pix1_d;
    logic [CNT_W-1:0]  hpos_q, hpos_d, vpos_q, vpos_d;
    logic [1:0]        state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d, good_inc_c;
    logic              herr_seen_q, herr_seen_d;
    logic              h_err_q, h_err_d, v_err_q, v_err_d;
    logic              hs_edge_c, vs_edge_c, frame_ok_c, visible_c;
    logic [CNT_W-1:0]  hx_c, vy_c;
    logic [CNT_W-1:0]  px_x_q, px_x_d, px_y_q, px_y_d;
    logic [3:0]        px_data_q, px_data_d;
    logic              px_valid_q, px_valid_d, frame_start_q, frame_start_d, locked_q, locked_d;

    // Input stage, counters and line/frame checks; hpos_d/vpos_d position the stage-1 sample.
    always_comb begin
        hs1_d       = hsync;
        vs1_d       = vsync;
        pix1_d      = pixel;
        hs2_d       = hs1_q;
        vs2_d       = vs1_q;
        hs_edge_c   = (hs1_q == SYNC_POL) && (hs2_q != SYNC_POL);
        vs_edge_c   = (vs1_q == SYNC_POL) && (vs2_q != SYNC_POL);
        hpos_d      = (hpos_q == CNT_MAX) ? CNT_MAX : hpos_q + CNT_W'(1);
        vpos_d      = vpos_q;
        if (hs_edge_c) begin
            hpos_d = '0;
        end
        if (vs_edge_c) begin
            vpos_d = '0;
        end else if (hs_edge_c && vpos_q != CNT_MAX) begin
            vpos_d = vpos_q + CNT_W'(1);
        end
        h_err_d     = ((hpos_d == CNT_MAX) && (hpos_q != CNT_MAX)) ||
                      (hs_edge_c && (state_q != S_IDLE) && (hpos_q != CNT_W'(H_TOTAL - 1)));
        frame_ok_c  = (vpos_q == CNT_W'(V_TOTAL - 1)) && !herr_seen_q && !h_err_d;
        v_err_d     = vs_edge_c && (state_q != S_IDLE) && !frame_ok_c;
        herr_seen_d = vs_edge_c ? 1'b0 : (herr_seen_q | h_err_d);
    end

    // Lock tracking: first vsync edge only arms measurement.
    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        good_inc_c = good_q + GOOD_W'(1);
        case (state_q)
            S_IDLE: begin
                if (vs_edge_c) begin
                    state_d = S_TRACK;
                    good_d  = '0;
                end
            end
            S_TRACK: begin
                if (h_err_d || v_err_d) begin
                    good_d = '0;
                end else if (vs_edge_c) begin
                    good_d = good_inc_c;
                    if (good_inc_c == GOOD_W'(LOCK_FRAMES)) begin
                        state_d = S_LOCKED;
                    end
                end
            end
            S_LOCKED: begin
                if (h_err_d || v_err_d) begin
                    state_d = S_TRACK;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                good_d  = '0;
            end
        endcase
    end

    // Visible mapping; offsets wrap below zero so one unsigned compare covers both bounds.
    always_comb begin
        hx_c          = hpos_d - CNT_W'(H_SYNC + H_BP);
        vy_c          = vpos_d - CNT_W'(V_SYNC + V_BP);
        visible_c     = (hx_c < CNT_W'(H_ACTIVE)) && (vy_c < CNT_W'(V_ACTIVE));
        px_valid_d    = visible_c && (state_d == S_LOCKED);
        px_x_d        = px_valid_d ? hx_c : '0;
        px_y_d        = px_valid_d ? vy_c : '0;
        px_data_d     = px_valid_d ? pix1_q : 4'h0;
        frame_start_d = px_valid_d && (hx_c == '0) && (vy_c == '0);
        locked_d      = (state_d == S_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs1_q         <= ~SYNC_POL;
            hs2_q         <= ~SYNC_POL;
            vs1_q         <= ~SYNC_POL;
            vs2_q         <= ~SYNC_POL;
            pix1_q        <= 4'h0;
            hpos_q        <= '0;
            vpos_q        <= '0;
            state_q       <= S_IDLE;
            good_q        <= '0;
            herr_seen_q   <= 1'b0;
            h_err_q       <= 1'b0;
            v_err_q       <= 1'b0;
            px_x_q        <= '0;
            px_y_q        <= '0;
            px_data_q     <= 4'h0;
            px_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            hs1_q         <= hs1_d;
            hs2_q         <= hs2_d;
            vs1_q         <= vs1_d;
            vs2_q         <= vs2_d;
            pix1_q        <= pix1_d;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            state_q       <= state_d;
            good_q        <= good_d;
            herr_seen_q   <= herr_seen_d;
            h_err_q       <= h_err_d;
            v_err_q       <= v_err_d;
            px_x_q        <= px_x_d;
            px_y_q        <= px_y_d;
            px_data_q     <= px_data_d;
            px_valid_q    <= px_valid_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
        end
    end

    assign px_x        = px_x_q;
    assign px_y        = px_y_q;
    assign px_data     = px_data_q;
    assign px_valid    = px_valid_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign h_err       = h_err_q;
    assign v_err       = v_err_q;

`ifdef VGA_RX_CRC_EN
    // CRC-16-CCITT, one nibble per visible pixel, MSB first.
    function automatic logic [15:0] crc_nibble(input logic [15:0] c, input logic [3:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 3; i >= 0; i--) begin
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    logic [15:0] crc_run_q, crc_run_d, frame_crc_q, frame_crc_d;
    logic        crc_valid_q, crc_valid_d;

    // Only frames closed cleanly while locked publish a CRC.
    always_comb begin
        crc_run_d   = crc_run_q;
        frame_crc_d = frame_crc_q;
        crc_valid_d = 1'b0;
        if (vs_edge_c) begin
            crc_run_d = 16'hFFFF;
            if (state_q == S_LOCKED && !v_err_d) begin
                frame_crc_d = crc_run_q;
                crc_valid_d = 1'b1;
            end
        end else if (px_valid_d) begin
            crc_run_d = crc_nibble(crc_run_q, pix1_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_run_q   <= 16'hFFFF;
            frame_crc_q <= 16'h0000;
            crc_valid_q <= 1'b0;
        end else begin
            crc_run_q   <= crc_run_d;
            frame_crc_q <= frame_crc_d;
            crc_valid_q <= crc_valid_d;
        end
    end

    assign frame_crc = frame_crc_q;
    assign crc_valid = crc_valid_q;
`else
    assign frame_crc = 16'h0000;
    assign crc_valid = 1'b0;
`endif
endmodule
